// File: rtl/mem_req_rr_arbiter.sv
// mem_req_rr_arbiter: round-robin arbiter sharing one tagged memory request channel across NB_REQ requesters.
// Define MEM_ARB_RSP_READY_EN to let requesters backpressure responses; otherwise responses are always accepted.
module mem_req_rr_arbiter #(
  parameter int NB_REQ          = 4,
  parameter int ADDR_WIDTH      = 64,
  parameter int DATA_WIDTH      = 512,
  parameter int ID_WIDTH        = 16,
  parameter int MAX_OUTSTANDING = 8,
  localparam int STRB_WIDTH     = DATA_WIDTH/8,
  localparam int IDX_W          = $clog2(NB_REQ),
  localparam int RID_W          = ID_WIDTH-IDX_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NB_REQ-1:0]            rq_req_valid,
  output logic [NB_REQ-1:0]            rq_req_ready,
  input  logic [NB_REQ*ADDR_WIDTH-1:0] rq_req_addr,
  input  logic [NB_REQ-1:0]            rq_req_wrn,
  input  logic [NB_REQ*RID_W-1:0]      rq_req_id,
  input  logic [NB_REQ*DATA_WIDTH-1:0] rq_req_data,
  input  logic [NB_REQ*STRB_WIDTH-1:0] rq_req_strb,
  input  logic [NB_REQ-1:0]            rq_req_amo,
  input  logic [NB_REQ*4-1:0]          rq_req_amo_op,
  output logic                         m_req_valid,
  input  logic                         m_req_ready,
  output logic [ADDR_WIDTH-1:0]        m_req_addr,
  output logic                         m_req_wrn,
  output logic [ID_WIDTH-1:0]          m_req_id,
  output logic [DATA_WIDTH-1:0]        m_req_data,
  output logic [STRB_WIDTH-1:0]        m_req_strb,
  output logic                         m_req_amo,
  output logic [3:0]                   m_req_amo_op,
  input  logic                         m_rd_res_valid,
  output logic                         m_rd_res_ready,
  input  logic [DATA_WIDTH-1:0]        m_rd_res_data,
  input  logic [ID_WIDTH-1:0]          m_rd_res_id,
  input  logic                         m_rd_res_err,
  input  logic                         m_wr_res_valid,
  output logic                         m_wr_res_ready,
  input  logic [ID_WIDTH-1:0]          m_wr_res_id,
  input  logic                         m_wr_res_err,
  output logic [NB_REQ-1:0]            rq_rd_res_valid,
  input  logic [NB_REQ-1:0]            rq_rd_res_ready,
  output logic [DATA_WIDTH-1:0]        rq_rd_res_data,
  output logic [RID_W-1:0]             rq_rd_res_id,
  output logic                         rq_rd_res_err,
  output logic [NB_REQ-1:0]            rq_wr_res_valid,
  input  logic [NB_REQ-1:0]            rq_wr_res_ready,
  output logic [RID_W-1:0]             rq_wr_res_id,
  output logic                         rq_wr_res_err,
  output logic                         err_bad_tag
);
  localparam int CW = $clog2(MAX_OUTSTANDING+1);
  logic [CW-1:0] cnt [NB_REQ];
  logic [CW-1:0] cnt_nxt [NB_REQ];
  int sum [NB_REQ];
  logic [NB_REQ-1:0] elig;
  logic [IDX_W-1:0] rr_ptr, grant_idx, rd_tag, wr_tag;
  logic grant_any, load, rd_bad, wr_bad, rd_acc, wr_acc, cnt_err;
  always_comb begin
    for (int i = 0; i < NB_REQ; i++) elig[i] = rq_req_valid[i] && (cnt[i] < CW'(MAX_OUTSTANDING));
  end
  // Walk offsets downward so the nearest eligible index at or after rr_ptr wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = NB_REQ-1; k >= 0; k--) begin
      if (elig[(int'(rr_ptr)+k) % NB_REQ]) begin
        grant_any = 1'b1;
        grant_idx = IDX_W'((int'(rr_ptr)+k) % NB_REQ);
      end
    end
  end
  assign load = (!m_req_valid || m_req_ready) && grant_any;
  assign rq_req_ready = load ? NB_REQ'(1) << grant_idx : '0;
  assign rd_tag = m_rd_res_id[ID_WIDTH-1 -: IDX_W];
  assign wr_tag = m_wr_res_id[ID_WIDTH-1 -: IDX_W];
  assign rd_bad = int'(rd_tag) >= NB_REQ;
  assign wr_bad = int'(wr_tag) >= NB_REQ;
  assign rq_rd_res_valid = (m_rd_res_valid && !rd_bad) ? NB_REQ'(1) << rd_tag : '0;
  assign rq_wr_res_valid = (m_wr_res_valid && !wr_bad) ? NB_REQ'(1) << wr_tag : '0;
  assign rq_rd_res_data = m_rd_res_data;
  assign rq_rd_res_id = m_rd_res_id[RID_W-1:0];
  assign rq_rd_res_err = m_rd_res_err;
  assign rq_wr_res_id = m_wr_res_id[RID_W-1:0];
  assign rq_wr_res_err = m_wr_res_err;
`ifdef MEM_ARB_RSP_READY_EN
  // Bad-tag responses are swallowed so they cannot stall the memory model.
  assign m_rd_res_ready = rd_bad || |(rq_rd_res_ready & (NB_REQ'(1) << rd_tag));
  assign m_wr_res_ready = wr_bad || |(rq_wr_res_ready & (NB_REQ'(1) << wr_tag));
`else
  logic unused_rsp_ready;
  assign unused_rsp_ready = ^{rq_rd_res_ready, rq_wr_res_ready};
  assign m_rd_res_ready = 1'b1;
  assign m_wr_res_ready = 1'b1;
`endif
  assign rd_acc = m_rd_res_valid && m_rd_res_ready && !rd_bad;
  assign wr_acc = m_wr_res_valid && m_wr_res_ready && !wr_bad;
  // Net grant/response delta per requester; an underflow clamps to zero and flags an error.
  always_comb begin
    cnt_err = 1'b0;
    for (int i = 0; i < NB_REQ; i++) begin
      sum[i] = int'(cnt[i]) + int'(load && grant_idx == IDX_W'(i))
             - int'(rd_acc && rd_tag == IDX_W'(i)) - int'(wr_acc && wr_tag == IDX_W'(i));
      cnt_nxt[i] = sum[i] < 0 ? '0 : CW'(sum[i]);
      cnt_err = cnt_err | (sum[i] < 0);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_req_valid <= 1'b0;
      m_req_addr <= '0;
      m_req_wrn <= 1'b0;
      m_req_id <= '0;
      m_req_data <= '0;
      m_req_strb <= '0;
      m_req_amo <= 1'b0;
      m_req_amo_op <= '0;
      rr_ptr <= '0;
      cnt <= '{default: '0};
      err_bad_tag <= 1'b0;
    end else begin
      if (load) begin
        m_req_valid <= 1'b1;
        m_req_addr <= rq_req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        m_req_wrn <= rq_req_wrn[grant_idx];
        m_req_id <= {grant_idx, rq_req_id[int'(grant_idx)*RID_W +: RID_W]};
        m_req_data <= rq_req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
        m_req_strb <= rq_req_strb[int'(grant_idx)*STRB_WIDTH +: STRB_WIDTH];
        m_req_amo <= rq_req_amo[grant_idx];
        m_req_amo_op <= rq_req_amo_op[int'(grant_idx)*4 +: 4];
        rr_ptr <= IDX_W'((int'(grant_idx)+1) % NB_REQ);
      end else if (m_req_ready) begin
        m_req_valid <= 1'b0;
      end
      cnt <= cnt_nxt;
      err_bad_tag <= err_bad_tag | (m_rd_res_valid && rd_bad) | (m_wr_res_valid && wr_bad) | cnt_err;
    end
  end
endmodule

// File: tb/tb_mem_req_rr_arbiter.sv
// tb_mem_req_rr_arbiter: directed bench with a per-cycle reference model of the arbiter.
// NB_REQ=3 so tag 3 is an unused (bad) tag.
module tb_mem_req_rr_arbiter;
  localparam int N = 3, AW = 16, DW = 32, SW = DW/8, IW = 16, IX = 2, RW = IW-IX, MAX = 8;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] rq_req_valid = '0, rq_req_ready, rq_req_wrn = '0, rq_req_amo = '0;
  logic [N*AW-1:0] rq_req_addr = '0;
  logic [N*RW-1:0] rq_req_id = '0;
  logic [N*DW-1:0] rq_req_data = '0;
  logic [N*SW-1:0] rq_req_strb = '0;
  logic [N*4-1:0] rq_req_amo_op = '0;
  logic m_req_valid, m_req_ready = 1'b0, m_req_wrn, m_req_amo;
  logic [AW-1:0] m_req_addr;
  logic [IW-1:0] m_req_id;
  logic [DW-1:0] m_req_data;
  logic [SW-1:0] m_req_strb;
  logic [3:0] m_req_amo_op;
  logic m_rd_res_valid = 1'b0, m_rd_res_ready, m_rd_res_err = 1'b0;
  logic [DW-1:0] m_rd_res_data = '0;
  logic [IW-1:0] m_rd_res_id = '0, m_wr_res_id = '0;
  logic m_wr_res_valid = 1'b0, m_wr_res_ready, m_wr_res_err = 1'b0;
  logic [N-1:0] rq_rd_res_valid, rq_rd_res_ready = '0, rq_wr_res_valid, rq_wr_res_ready = '0;
  logic [DW-1:0] rq_rd_res_data;
  logic [RW-1:0] rq_rd_res_id, rq_wr_res_id;
  logic rq_rd_res_err, rq_wr_res_err, err_bad_tag;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  mem_req_rr_arbiter #(.NB_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_OUTSTANDING(MAX)) dut (
    .clk(clk), .rst(rst), .rq_req_valid(rq_req_valid), .rq_req_ready(rq_req_ready),
    .rq_req_addr(rq_req_addr), .rq_req_wrn(rq_req_wrn), .rq_req_id(rq_req_id),
    .rq_req_data(rq_req_data), .rq_req_strb(rq_req_strb), .rq_req_amo(rq_req_amo),
    .rq_req_amo_op(rq_req_amo_op), .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
    .m_req_addr(m_req_addr), .m_req_wrn(m_req_wrn), .m_req_id(m_req_id), .m_req_data(m_req_data),
    .m_req_strb(m_req_strb), .m_req_amo(m_req_amo), .m_req_amo_op(m_req_amo_op),
    .m_rd_res_valid(m_rd_res_valid), .m_rd_res_ready(m_rd_res_ready), .m_rd_res_data(m_rd_res_data),
    .m_rd_res_id(m_rd_res_id), .m_rd_res_err(m_rd_res_err), .m_wr_res_valid(m_wr_res_valid),
    .m_wr_res_ready(m_wr_res_ready), .m_wr_res_id(m_wr_res_id), .m_wr_res_err(m_wr_res_err),
    .rq_rd_res_valid(rq_rd_res_valid), .rq_rd_res_ready(rq_rd_res_ready), .rq_rd_res_data(rq_rd_res_data),
    .rq_rd_res_id(rq_rd_res_id), .rq_rd_res_err(rq_rd_res_err), .rq_wr_res_valid(rq_wr_res_valid),
    .rq_wr_res_ready(rq_wr_res_ready), .rq_wr_res_id(rq_wr_res_id), .rq_wr_res_err(rq_wr_res_err),
    .err_bad_tag(err_bad_tag)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, act, exp, $time);
    end
  endtask
  // Reference model: outstanding counts per requester, round-robin start, and the expected output slot.
  int m_cnt [N], n_cnt [N];
  int m_rr = 0, n_rr = 0;
  bit m_valid = 0, n_valid = 0, m_err = 0, n_err = 0;
  logic [AW-1:0] m_addr = '0, n_addr = '0;
  logic [IW-1:0] m_id = '0, n_id = '0;
  logic [DW-1:0] m_data = '0, n_data = '0;
  logic [SW-1:0] m_strb = '0, n_strb = '0;
  logic [3:0] m_op = '0, n_op = '0;
  logic m_wrn = 0, n_wrn = 0, m_amo = 0, n_amo = 0;
  always @(negedge clk) begin : model
    int g, rt, wt, s;
    bit ld, erd, ewr;
    if (!rst) begin
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && rq_req_valid[(m_rr+k)%N] && m_cnt[(m_rr+k)%N] < MAX) g = (m_rr+k)%N;
      ld = (!m_valid || m_req_ready) && g >= 0;
      chk("rq_req_ready", rq_req_ready, ld ? (64'd1 << g) : 64'd0);
      chk("m_req_valid", m_req_valid, m_valid);
      chk("m_req_addr", m_req_addr, m_addr);
      chk("m_req_id", m_req_id, m_id);
      chk("m_req_data", m_req_data, m_data);
      chk("m_req_misc", {m_req_wrn, m_req_amo, m_req_amo_op, m_req_strb}, {m_wrn, m_amo, m_op, m_strb});
      chk("err_bad_tag", err_bad_tag, m_err);
      rt = int'(m_rd_res_id[IW-1 -: IX]);
      wt = int'(m_wr_res_id[IW-1 -: IX]);
`ifdef MEM_ARB_RSP_READY_EN
      erd = (rt >= N) ? 1'b1 : rq_rd_res_ready[rt];
      ewr = (wt >= N) ? 1'b1 : rq_wr_res_ready[wt];
`else
      erd = 1'b1;
      ewr = 1'b1;
`endif
      chk("m_rd_res_ready", m_rd_res_ready, erd);
      chk("m_wr_res_ready", m_wr_res_ready, ewr);
      chk("rq_rd_res_valid", rq_rd_res_valid, (m_rd_res_valid && rt < N) ? (64'd1 << rt) : 64'd0);
      chk("rq_wr_res_valid", rq_wr_res_valid, (m_wr_res_valid && wt < N) ? (64'd1 << wt) : 64'd0);
      chk("rq_rd_payload", {rq_rd_res_data, rq_rd_res_id, rq_rd_res_err}, {m_rd_res_data, m_rd_res_id[RW-1:0], m_rd_res_err});
      chk("rq_wr_payload", {rq_wr_res_id, rq_wr_res_err}, {m_wr_res_id[RW-1:0], m_wr_res_err});
      n_valid = ld ? 1'b1 : (m_req_ready ? 1'b0 : m_valid);
      n_rr = ld ? (g+1)%N : m_rr;
      n_addr = m_addr; n_id = m_id; n_data = m_data; n_strb = m_strb; n_op = m_op; n_wrn = m_wrn; n_amo = m_amo;
      if (ld) begin
        n_addr = rq_req_addr[g*AW +: AW];
        n_id = {IX'(g), rq_req_id[g*RW +: RW]};
        n_data = rq_req_data[g*DW +: DW];
        n_strb = rq_req_strb[g*SW +: SW];
        n_op = rq_req_amo_op[g*4 +: 4];
        n_wrn = rq_req_wrn[g];
        n_amo = rq_req_amo[g];
      end
      n_err = m_err || (m_rd_res_valid && rt >= N) || (m_wr_res_valid && wt >= N);
      for (int i = 0; i < N; i++) begin
        s = m_cnt[i] + ((ld && g == i) ? 1 : 0) - ((m_rd_res_valid && erd && rt == i) ? 1 : 0)
          - ((m_wr_res_valid && ewr && wt == i) ? 1 : 0);
        if (s < 0) begin
          s = 0;
          n_err = 1'b1;
        end
        n_cnt[i] = s;
      end
    end
  end
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 0; m_rr <= 0; m_err <= 0; m_addr <= '0; m_id <= '0; m_data <= '0;
      m_strb <= '0; m_op <= '0; m_wrn <= 0; m_amo <= 0;
      for (int i = 0; i < N; i++) m_cnt[i] <= 0;
    end else begin
      m_valid <= n_valid; m_rr <= n_rr; m_err <= n_err; m_addr <= n_addr; m_id <= n_id; m_data <= n_data;
      m_strb <= n_strb; m_op <= n_op; m_wrn <= n_wrn; m_amo <= n_amo;
      for (int i = 0; i < N; i++) m_cnt[i] <= n_cnt[i];
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rq_req_valid = '0; m_req_ready = 1'b0; m_rd_res_valid = 1'b0; m_wr_res_valid = 1'b0;
    rq_rd_res_ready = '0; rq_wr_res_ready = '0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
  endtask
  initial begin
    rq_req_addr = {16'h3300, 16'h2200, 16'h1100};
    rq_req_id = {14'h0222, 14'h0111, 14'h0005};
    rq_req_data = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    rq_req_strb = {4'hF, 4'h3, 4'h1};
    rq_req_wrn = 3'b101;
    rq_req_amo = 3'b010;
    rq_req_amo_op = {4'h3, 4'h2, 4'h1};
    m_rd_res_data = 32'hDEAD_BEEF;
    tick;
    tick;
    chk("reset_m_req_valid", m_req_valid, 0);
    chk("reset_m_req_id", m_req_id, 0);
    chk("reset_m_req_addr", m_req_addr, 0);
    chk("reset_err", err_bad_tag, 0);
    rst = 1'b0;
    // all requesters valid, downstream always ready: strict rotation
    rq_req_valid = 3'b111; m_req_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_grant", rq_req_ready, 64'd1 << (k%3));
      if (k > 0) chk("rr_tag", m_req_id[IW-1 -: IX], (k-1)%3);
      tick;
    end
    // downstream stall: slot holds requester 2's request, no grants
    m_req_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_ready", rq_req_ready, 0);
      chk("stall_id", m_req_id, 16'h8222);
      chk("stall_addr", m_req_addr, 16'h3300);
      tick;
    end
    m_req_ready = 1'b1;
    #1 chk("stall_resume_grant", rq_req_ready, 3'b001);
    tick;
    // outstanding limit on requester 1
    do_reset;
    rq_req_valid = 3'b010; m_req_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1 chk("limit_grant", rq_req_ready, 3'b010);
      tick;
    end
    for (int k = 0; k < 3; k++) begin
      #1 chk("limit_blocked", rq_req_ready, 0);
      tick;
    end
    m_rd_res_valid = 1'b1; m_rd_res_id = 16'h4033; m_rd_res_err = 1'b1; rq_rd_res_ready = 3'b111;
    #1;
    chk("limit_rsp_valid", rq_rd_res_valid, 3'b010);
    chk("limit_rsp_id", rq_rd_res_id, 14'h0033);
    chk("limit_rsp_err", rq_rd_res_err, 1);
    chk("limit_still_blocked", rq_req_ready, 0);
    tick;
    m_rd_res_valid = 1'b0; m_rd_res_err = 1'b0;
    #1 chk("limit_resume", rq_req_ready, 3'b010);
    tick;
    #1 chk("limit_reblocked", rq_req_ready, 0);
    rq_req_valid = '0;
    tick;
    // grant and response to the same requester in one cycle
    do_reset;
    rq_req_valid = 3'b100; m_req_ready = 1'b1; rq_rd_res_ready = 3'b111;
    for (int k = 0; k < 3; k++) begin
      #1 chk("net_pre_grant", rq_req_ready, 3'b100);
      tick;
    end
    m_rd_res_valid = 1'b1; m_rd_res_id = 16'h8007;
    #1;
    chk("net_grant", rq_req_ready, 3'b100);
    chk("net_rsp", rq_rd_res_valid, 3'b100);
    tick;
    m_rd_res_valid = 1'b0;
    chk("net_model_cnt", m_cnt[2], 3);
    for (int k = 0; k < 5; k++) begin
      #1 chk("net_fill", rq_req_ready, 3'b100);
      tick;
    end
    #1 chk("net_full", rq_req_ready, 0);
    rq_req_valid = '0;
    tick;
    // bad tag response
    do_reset;
    m_rd_res_valid = 1'b1; m_rd_res_id = 16'hC005;
    #1;
    chk("bad_no_fwd", rq_rd_res_valid, 0);
    chk("bad_consumed", m_rd_res_ready, 1);
    chk("bad_err_before", err_bad_tag, 0);
    tick;
    m_rd_res_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk("bad_err_sticky", err_bad_tag, 1);
      tick;
    end
    do_reset;
    #1 chk("bad_err_cleared", err_bad_tag, 0);
    // response backpressure and write path
    rq_req_valid = 3'b001; m_req_ready = 1'b1;
    tick;
    tick;
    rq_req_valid = '0;
    tick;
    m_rd_res_valid = 1'b1; m_rd_res_id = 16'h0005; rq_rd_res_ready = 3'b110;
    #1;
    chk("bp_valid", rq_rd_res_valid, 3'b001);
    chk("bp_id", rq_rd_res_id, 5);
`ifdef MEM_ARB_RSP_READY_EN
    chk("bp_ready_held", m_rd_res_ready, 0);
    tick;
    #1 chk("bp_still_held", m_rd_res_ready, 0);
    rq_rd_res_ready = 3'b111;
    #1 chk("bp_release", m_rd_res_ready, 1);
`else
    chk("bp_legacy_ready", m_rd_res_ready, 1);
`endif
    tick;
    m_rd_res_valid = 1'b0;
    m_wr_res_valid = 1'b1; m_wr_res_id = 16'h0009; m_wr_res_err = 1'b1; rq_wr_res_ready = 3'b111;
    #1;
    chk("wr_valid", rq_wr_res_valid, 3'b001);
    chk("wr_id", rq_wr_res_id, 9);
    chk("wr_err", rq_wr_res_err, 1);
    tick;
    m_wr_res_id = 16'h4001; m_wr_res_err = 1'b0;
    #1 chk("underflow_fwd", rq_wr_res_valid, 3'b010);
    tick;
    m_wr_res_valid = 1'b0;
    #1 chk("underflow_err", err_bad_tag, 1);
    // asynchronous reset drops a pending slot immediately
    do_reset;
    rq_req_valid = 3'b001; m_req_ready = 1'b0;
    tick;
    #1 chk("async_slot_full", m_req_valid, 1);
    rst = 1'b1;
    #1;
    chk("async_valid_drop", m_req_valid, 0);
    chk("async_addr_clr", m_req_addr, 0);
    tick;
    rst = 1'b0; m_req_ready = 1'b1;
    #1;
    chk("async_model_cnt", m_cnt[0], 0);
    chk("async_regrant", rq_req_ready, 3'b001);
    tick;
    rq_req_valid = '0;
    tick;
    tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
